// File: rtl/key_input_conditioner.sv
// -----------------------------------------------------------------------------
// key_input_conditioner
//
// Turns raw, bouncy pushbutton pins into clean key events for the digital lock
// FSM. Each key is synchronised to `clock`, debounced by its own four-state
// machine, and converted into a one-cycle press pulse. The debounced levels are
// also exported for display and idle logic.
//
// Parameters:
//   NUM_KEYS        number of pushbuttons (width of every key bus)
//   DEBOUNCE_CYCLES consecutive stable samples needed to accept a press/release
//   ACTIVE_LOW      1: raw 0 means pressed; 0: raw 1 means pressed
//
// Ports:
//   clock       system clock, rising edge
//   reset       asynchronous, active-high
//   key_raw     unsynchronised button pins
//   key_pulse   registered, one cycle high per accepted press of each key
//   key_held    registered debounced level (PRESSED or RELEASE_WAIT)
//   any_held    registered OR of key_held
//
// Build option:
//   MULTI_KEY_LOCKOUT_EN  when defined, a press is not pulsed while any other
//                         key is held, and among keys qualifying on the same
//                         edge only the lowest index pulses (key_pulse is
//                         zero or one-hot). Undefined: every press pulses.
// -----------------------------------------------------------------------------
module key_input_conditioner #(
    parameter int NUM_KEYS        = 4,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter bit ACTIVE_LOW      = 1'b1
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [NUM_KEYS-1:0] key_raw,
    output logic [NUM_KEYS-1:0] key_pulse,
    output logic [NUM_KEYS-1:0] key_held,
    output logic                any_held
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    // A release completes once the counter has reached DEBOUNCE_CYCLES; a press
    // completes on the sample that makes DEBOUNCE_CYCLES pressed samples in a
    // row, i.e. while the counter still holds DEBOUNCE_CYCLES-1.
    localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_PRESS = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    // Synchroniser reset value is the released pin level.
    localparam logic [NUM_KEYS-1:0] SYNC_RELEASED = {NUM_KEYS{ACTIVE_LOW}};

    typedef enum logic [1:0] {
        RELEASED,
        PRESS_WAIT,
        PRESSED,
        RELEASE_WAIT
    } deb_state_e;

    logic [NUM_KEYS-1:0] sync1_q;
    logic [NUM_KEYS-1:0] sync2_q;
    logic [NUM_KEYS-1:0] pressed_s;

    deb_state_e          state_q [NUM_KEYS];
    logic [CNT_W-1:0]    cnt_q   [NUM_KEYS];
    logic [NUM_KEYS-1:0] held_q;

    logic [NUM_KEYS-1:0] press_req;
    logic [NUM_KEYS-1:0] pulse_d;
    logic [NUM_KEYS-1:0] pulse_q;
    logic                any_q;

    // -------------------------------------------------------------------------
    // Two-flop synchroniser, then polarity correction so pressed_s=1 is pressed
    // -------------------------------------------------------------------------
    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge value of its neighbours, exactly like the hardware.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync1_q <= SYNC_RELEASED;
            sync2_q <= SYNC_RELEASED;
        end else begin
            sync1_q <= key_raw;
            sync2_q <= sync1_q;
        end
    end

    assign pressed_s = ACTIVE_LOW ? ~sync2_q : sync2_q;

    // -------------------------------------------------------------------------
    // Press request: asserted on the edge that will move a key into PRESSED
    // from RELEASED (single-sample debounce) or from PRESS_WAIT.
    // -------------------------------------------------------------------------
    // NOTE: every combinational output gets a default before the loop, so no
    // path through the block leaves it unassigned and no latch is inferred.
    always_comb begin
        press_req = '0;
        for (int k = 0; k < NUM_KEYS; k++) begin
            case (state_q[k])
                RELEASED:   press_req[k] = pressed_s[k] && (DEBOUNCE_CYCLES == 1);
                PRESS_WAIT: press_req[k] = pressed_s[k] && (cnt_q[k] == CNT_PRESS);
                default:    press_req[k] = 1'b0;
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Per-key debounce FSM with registered held level
    // -------------------------------------------------------------------------
    // NOTE: the per-key state and counters are a handful of flops, not a RAM,
    // so they are all cleared by reset; a key held through reset must start
    // again from RELEASED and re-qualify.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < NUM_KEYS; k++) begin
                state_q[k] <= RELEASED;
                cnt_q[k]   <= '0;
            end
            held_q <= '0;
        end else begin
            for (int k = 0; k < NUM_KEYS; k++) begin
                case (state_q[k])
                    RELEASED: begin
                        if (press_req[k]) begin
                            state_q[k] <= PRESSED;
                            cnt_q[k]   <= '0;
                            held_q[k]  <= 1'b1;
                        end else if (pressed_s[k]) begin
                            state_q[k] <= PRESS_WAIT;
                            cnt_q[k]   <= CNT_ONE;
                        end
                    end
                    PRESS_WAIT: begin
                        if (!pressed_s[k]) begin
                            // Bounce: too few pressed samples in a row.
                            state_q[k] <= RELEASED;
                            cnt_q[k]   <= '0;
                        end else if (press_req[k]) begin
                            state_q[k] <= PRESSED;
                            cnt_q[k]   <= '0;
                            held_q[k]  <= 1'b1;
                        end else if (cnt_q[k] != CNT_MAX) begin
                            cnt_q[k] <= cnt_q[k] + CNT_ONE;
                        end
                    end
                    PRESSED: begin
                        if (!pressed_s[k]) begin
                            state_q[k] <= RELEASE_WAIT;
                            cnt_q[k]   <= CNT_ONE;
                        end
                    end
                    RELEASE_WAIT: begin
                        if (pressed_s[k]) begin
                            // Release glitch: back to PRESSED without a new pulse.
                            state_q[k] <= PRESSED;
                            cnt_q[k]   <= '0;
                        end else if (cnt_q[k] == CNT_MAX) begin
                            state_q[k] <= RELEASED;
                            cnt_q[k]   <= '0;
                            held_q[k]  <= 1'b0;
                        end else begin
                            cnt_q[k] <= cnt_q[k] + CNT_ONE;
                        end
                    end
                    default: begin
                        state_q[k] <= RELEASED;
                        cnt_q[k]   <= '0;
                        held_q[k]  <= 1'b0;
                    end
                endcase
            end
        end
    end

    // -------------------------------------------------------------------------
    // Pulse arbitration
    // -------------------------------------------------------------------------
    always_comb begin
        pulse_d = press_req;
`ifdef MULTI_KEY_LOCKOUT_EN
        // A requesting key is never itself held, so any held bit belongs to
        // another key and blocks the request.
        if (|held_q) begin
            pulse_d = '0;
        end else begin
            // Isolate the lowest set bit.
            pulse_d = press_req & (~press_req + NUM_KEYS'(1));
        end
`endif
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pulse_q <= '0;
            any_q   <= 1'b0;
        end else begin
            pulse_q <= pulse_d;
            any_q   <= |held_q;
        end
    end

    assign key_pulse = pulse_q;
    assign key_held  = held_q;
    assign any_held  = any_q;

endmodule

// File: tb/tb_key_input_conditioner.sv
// -----------------------------------------------------------------------------
// Bench for key_input_conditioner with NUM_KEYS=4, DEBOUNCE_CYCLES=4,
// ACTIVE_LOW=1. A run-length model predicts the outputs every cycle; directed
// scenarios add hand-computed literal expectations at fixed edges.
// -----------------------------------------------------------------------------
module tb_key_input_conditioner;

    localparam int NK = 4;
    localparam int D  = 4;

    logic          clock;
    logic          reset;
    logic [NK-1:0] key_raw;
    logic [NK-1:0] key_pulse;
    logic [NK-1:0] key_held;
    logic          any_held;

    int tests = 0;
    int fails = 0;

    key_input_conditioner #(
        .NUM_KEYS       (NK),
        .DEBOUNCE_CYCLES(D),
        .ACTIVE_LOW     (1'b1)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .key_raw  (key_raw),
        .key_pulse(key_pulse),
        .key_held (key_held),
        .any_held (any_held)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic wait_n(input int n);
        repeat (n) @(negedge clock);
    endtask

    // -------------------------------------------------------------------------
    // Model: a key becomes held after D pressed samples in a row and released
    // after D+1 released samples in a row. Samples reach the debouncer two
    // edges after the pin is read.
    // -------------------------------------------------------------------------
    logic [NK-1:0] m1, m2;
    int            run_p [NK];
    int            run_r [NK];
    logic [NK-1:0] exp_pulse, exp_held;
    logic          exp_any;

    always @(posedge clock) begin
        logic [NK-1:0] s;
        logic [NK-1:0] req;
        logic [NK-1:0] lvl;
        logic [NK-1:0] prev_held;
        if (reset) begin
            m1 = '0; m2 = '0;
            for (int k = 0; k < NK; k++) begin run_p[k] = 0; run_r[k] = 0; end
            exp_pulse = '0; exp_held = '0; exp_any = 1'b0;
        end else begin
            s  = m2;
            m2 = m1;
            m1 = ~key_raw;
            prev_held = exp_held;
            lvl = exp_held;
            req = '0;
            for (int k = 0; k < NK; k++) begin
                if (s[k]) begin run_p[k]++; run_r[k] = 0; end
                else      begin run_r[k]++; run_p[k] = 0; end
                if (!lvl[k] && run_p[k] >= D) begin
                    lvl[k] = 1'b1;
                    req[k] = 1'b1;
                end else if (lvl[k] && run_r[k] >= D + 1) begin
                    lvl[k] = 1'b0;
                end
            end
`ifdef MULTI_KEY_LOCKOUT_EN
            if (prev_held != '0) req = '0;
            else begin
                for (int k = 0; k < NK; k++)
                    if (req[k]) begin req = '0; req[k] = 1'b1; break; end
            end
`endif
            exp_any   = |prev_held;
            exp_held  = lvl;
            exp_pulse = req;
        end
    end

    // Every-cycle comparison against the model.
    bit cmp_en = 1'b0;
    initial begin
        forever begin
            @(negedge clock);
            #1;
            if (cmp_en) begin
                check("cyc_pulse", key_pulse, reset ? '0 : exp_pulse);
                check("cyc_held",  key_held,  reset ? '0 : exp_held);
                check("cyc_any",   any_held,  reset ? 1'b0 : exp_any);
            end
        end
    end

    // Observed pulse counts per key.
    int pcnt [NK];
    initial for (int k = 0; k < NK; k++) pcnt[k] = 0;
    always @(negedge clock)
        if (!reset) for (int k = 0; k < NK; k++) if (key_pulse[k]) pcnt[k]++;

    // -------------------------------------------------------------------------
    // Directed scenarios
    // -------------------------------------------------------------------------
    initial begin
        int base;
        reset   = 1'b1;
        key_raw = '1;
        wait_n(3);
        check("rst_pulse", key_pulse, 4'b0000);
        check("rst_held",  key_held,  4'b0000);
        check("rst_any",   any_held,  1'b0);
        reset  = 1'b0;
        cmp_en = 1'b1;
        wait_n(5);

        // Clean press of key 0: pulse at E1+5, any_held at E1+6.
        key_raw = 4'b1110;
        wait_n(5);
        check("press_early_pulse", key_pulse, 4'b0000);
        check("press_early_held",  key_held,  4'b0000);
        wait_n(1);
        check("press_pulse", key_pulse, 4'b0001);
        check("press_held",  key_held,  4'b0001);
        check("press_any0",  any_held,  1'b0);
        wait_n(1);
        check("press_pulse_fall", key_pulse, 4'b0000);
        check("press_any1",       any_held,  1'b1);
        wait_n(3);
        // Release: held falls at E1'+6.
        key_raw = 4'b1111;
        wait_n(6);
        check("rel_held_still", key_held, 4'b0001);
        wait_n(1);
        check("rel_held_fall", key_held, 4'b0000);
        wait_n(5);

        // Bounce on key 1: runs of 2 samples never qualify.
        base = pcnt[1];
        for (int i = 0; i < 5; i++) begin
            key_raw[1] = 1'b0; wait_n(2);
            key_raw[1] = 1'b1; wait_n(2);
        end
        wait_n(10);
        check("bounce_pulses", pcnt[1] - base, 0);
        check("bounce_held",   key_held, 4'b0000);

        // Long hold of key 3 with a 2-cycle release glitch.
        base = pcnt[3];
        key_raw = 4'b0111; wait_n(50);
        key_raw = 4'b1111; wait_n(2);
        key_raw = 4'b0111; wait_n(48);
        check("hold_held",   key_held, 4'b1000);
        key_raw = 4'b1111; wait_n(12);
        check("hold_pulses", pcnt[3] - base, 1);
        check("hold_rel",    key_held, 4'b0000);

        // Simultaneous press of keys 0 and 2.
        key_raw = 4'b1010;
        wait_n(6);
`ifdef MULTI_KEY_LOCKOUT_EN
        check("simul_pulse", key_pulse, 4'b0001);
`else
        check("simul_pulse", key_pulse, 4'b0101);
`endif
        check("simul_held", key_held, 4'b0101);
        key_raw = 4'b1111; wait_n(12);

        // Key 2 pressed while key 0 is already held.
        key_raw = 4'b1110; wait_n(8);
        key_raw = 4'b1010; wait_n(6);
`ifdef MULTI_KEY_LOCKOUT_EN
        check("second_pulse", key_pulse, 4'b0000);
`else
        check("second_pulse", key_pulse, 4'b0100);
`endif
        check("second_held", key_held, 4'b0101);
        key_raw = 4'b1111; wait_n(12);

        // Reset mid-debounce with key 1 held throughout.
        key_raw = 4'b1101;
        wait_n(2);
        reset = 1'b1;
        #1;
        check("rstmid_pulse", key_pulse, 4'b0000);
        check("rstmid_held",  key_held,  4'b0000);
        wait_n(3);
        check("rstmid_any", any_held, 1'b0);
        reset = 1'b0;
        wait_n(5);
        check("rstpost_early", key_pulse, 4'b0000);
        wait_n(1);
        check("rstpost_pulse", key_pulse, 4'b0010);
        check("rstpost_held",  key_held,  4'b0010);
        key_raw = 4'b1111; wait_n(12);
        check("final_held", key_held, 4'b0000);

        cmp_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
